// File: rtl/i2c_chan_sel_ctrl.sv
// Channel-select controller for a 2:1 I2C passthrough mux: filters the selected
// bus, tracks START/STOP and only moves sel while the bus is idle.
module i2c_chan_sel_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3,
  parameter int HOLDOFF_CYC = 16,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic clk,
  input  logic rst,
  input  logic req_sel,
  input  logic scl_i,
  input  logic sda_i,
  output logic sel,
  output logic busy,
  output logic switch_done,
  output logic timeout
);

  localparam int FW = $clog2(FILT_LEN + 1);
  localparam int HW = (HOLDOFF_CYC > 0) ? $clog2(HOLDOFF_CYC + 1) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, SWITCH, BUSY, HOLDOFF} state_e;

  // Index 0 carries SCL, index 1 carries SDA through the input path.
  logic [1:0]                  pin;
  logic [1:0][SYNC_STAGES-1:0] sync_q, sync_d;
  logic [1:0][FW-1:0]          fcnt_q, fcnt_d;
  logic [1:0]                  flt_q, flt_d;
  logic [1:0]                  prev_q, prev_d;

  state_e        state_q, state_d;
  logic          sel_q, sel_d;
  logic          busy_q, busy_d;
  logic          switch_done_q, switch_done_d;
  logic          timeout_q, timeout_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [TW-1:0] tmo_q, tmo_d;

  logic start_cond, stop_cond, scl_changed;

  assign pin = {sda_i, scl_i};

  // NOTE: every variable gets a default at the top of always_comb, so no path can infer a latch.
  always_comb begin
    sync_d = sync_q;
    fcnt_d = fcnt_q;
    flt_d  = flt_q;
    prev_d = flt_q;
    for (int i = 0; i < 2; i++) begin
      sync_d[i] = {sync_q[i][SYNC_STAGES-2:0], pin[i]};
      if (sync_q[i][SYNC_STAGES-1] == flt_q[i]) begin
        fcnt_d[i] = '0;
      end else if (fcnt_q[i] >= FW'(FILT_LEN - 1)) begin
        flt_d[i]  = sync_q[i][SYNC_STAGES-1];
        fcnt_d[i] = '0;
      end else begin
        fcnt_d[i] = fcnt_q[i] + FW'(1);
      end
    end
    // The newly selected bus is assumed idle-high; stale history from the old bus is discarded.
    if (state_q == SWITCH) begin
      sync_d = '1;
      fcnt_d = '0;
      flt_d  = '1;
      prev_d = '1;
    end
  end

  assign start_cond  = prev_q[0] & prev_q[1] & flt_q[0] & ~flt_q[1];
  assign stop_cond   = prev_q[0] & ~prev_q[1] & flt_q[0] & flt_q[1];
  assign scl_changed = flt_q[0] ^ prev_q[0];

  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    switch_done_d = 1'b0;
    timeout_d     = 1'b0;
    hold_d        = hold_q;
    tmo_d         = tmo_q;
    case (state_q)
      IDLE: begin
        tmo_d = '0;
        if (start_cond) begin
          state_d = BUSY;
        end else if (req_sel != sel_q) begin
          state_d       = SWITCH;
          sel_d         = req_sel;
          switch_done_d = 1'b1;
        end
      end
      SWITCH: begin
        state_d = HOLDOFF;
        hold_d  = HW'(HOLDOFF_CYC);
      end
      BUSY: begin
        if (stop_cond) begin
          state_d = HOLDOFF;
          hold_d  = HW'(HOLDOFF_CYC);
          tmo_d   = '0;
        end else if (scl_changed) begin
          tmo_d = '0;
        end else if (tmo_q >= TW'(TIMEOUT_CYC - 1)) begin
          state_d   = HOLDOFF;
          hold_d    = HW'(HOLDOFF_CYC);
          tmo_d     = '0;
          timeout_d = 1'b1;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      HOLDOFF: begin
        if (start_cond) begin
          state_d = BUSY;
          tmo_d   = '0;
        end else if (hold_q <= HW'(1)) begin
          state_d = IDLE;
          hold_d  = '0;
        end else begin
          hold_d = hold_q - HW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q        <= '1;
      fcnt_q        <= '0;
      flt_q         <= '1;
      prev_q        <= '1;
      state_q       <= IDLE;
      sel_q         <= 1'b0;
      busy_q        <= 1'b0;
      switch_done_q <= 1'b0;
      timeout_q     <= 1'b0;
      hold_q        <= '0;
      tmo_q         <= '0;
    end else begin
      sync_q        <= sync_d;
      fcnt_q        <= fcnt_d;
      flt_q         <= flt_d;
      prev_q        <= prev_d;
      state_q       <= state_d;
      sel_q         <= sel_d;
      busy_q        <= busy_d;
      switch_done_q <= switch_done_d;
      timeout_q     <= timeout_d;
      hold_q        <= hold_d;
      tmo_q         <= tmo_d;
    end
  end

  assign sel         = sel_q;
  assign busy        = busy_q;
  assign switch_done = switch_done_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_i2c_chan_sel_ctrl.sv
// Directed bench for i2c_chan_sel_ctrl; switch/timeout pulses are matched
// against a scoreboard of hand-computed (kind, sel, cycle) expectations.
module tb_i2c_chan_sel_ctrl;

  logic clk = 1'b0;
  logic rst, req_sel, scl_i, sda_i;
  logic sel, busy, switch_done, timeout;

  i2c_chan_sel_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .req_sel     (req_sel),
    .scl_i       (scl_i),
    .sda_i       (sda_i),
    .sel         (sel),
    .busy        (busy),
    .switch_done (switch_done),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0] kind;  // {timeout, switch_done}
    logic       sel;
    int         cyc;
  } ev_t;

  localparam logic [1:0] EV_SW  = 2'b01;
  localparam logic [1:0] EV_TMO = 2'b10;

  ev_t sb[$];
  ev_t mon_e;
  int  n_checks = 0;
  int  n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic expect_ev(input logic [1:0] kind, input logic s, input int at);
    sb.push_back('{kind, s, at});
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // Monitor: every output pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (switch_done || timeout) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", {30'd0, timeout, switch_done}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("ev_kind", {30'd0, timeout, switch_done}, {30'd0, mon_e.kind});
        check("ev_sel", {31'd0, sel}, {31'd0, mon_e.sel});
        check("ev_cycle", cyc, mon_e.cyc);
      end
    end
  end

  initial begin
    int c, a, b, g, s, t, u;
    rst = 1'b1; req_sel = 1'b1; scl_i = 1'b1; sda_i = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_sel", {31'd0, sel}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_switch_done", {31'd0, switch_done}, 32'd0);
    check("rst_timeout", {31'd0, timeout}, 32'd0);

    // Idle bus with a pending request: switch on first edge, then 16-clock holdoff.
    c = cyc;
    rst = 1'b0;
    expect_ev(EV_SW, 1'b1, c + 1);
    wait_cyc(c + 1);  check("t1_sel", {31'd0, sel}, 32'd1);
    check("t1_busy_start", {31'd0, busy}, 32'd1);
    wait_cyc(c + 17); check("t1_busy_last", {31'd0, busy}, 32'd1);
    wait_cyc(c + 18); check("t1_busy_end", {31'd0, busy}, 32'd0);
    check("t1_drained", sb.size(), 32'd0);

    // Full transaction with a request arriving mid-way; switch only after STOP+holdoff.
    a = cyc;
    sda_i = 1'b0;
    wait_cyc(a + 5); check("t2_busy_pre", {31'd0, busy}, 32'd0);
    wait_cyc(a + 6); check("t2_busy_start", {31'd0, busy}, 32'd1);
    wait_cyc(a + 8);
    for (int p = 0; p < 9; p++) begin
      scl_i = 1'b0;
      repeat (8) @(negedge clk);
      if (p == 4) req_sel = 1'b0;
      scl_i = 1'b1;
      repeat (8) @(negedge clk);
    end
    check("t2_sel_mid", {31'd0, sel}, 32'd1);
    check("t2_busy_mid", {31'd0, busy}, 32'd1);
    b = cyc;
    sda_i = 1'b1;
    expect_ev(EV_SW, 1'b0, b + 23);
    wait_cyc(b + 22);
    check("t2_sel_hold", {31'd0, sel}, 32'd1);
    check("t2_busy_idle", {31'd0, busy}, 32'd0);
    wait_cyc(b + 23); check("t2_sel_new", {31'd0, sel}, 32'd0);
    wait_cyc(b + 41);
    check("t2_drained", sb.size(), 32'd0);

    // 2-clock SDA glitch in IDLE must be filtered out.
    g = cyc;
    sda_i = 1'b0;
    wait_cyc(g + 2); sda_i = 1'b1;
    wait_cyc(g + 6);  check("t3_busy_a", {31'd0, busy}, 32'd0);
    wait_cyc(g + 12); check("t3_busy_b", {31'd0, busy}, 32'd0);

    // START in the same cycle IDLE first sees a new request: START wins.
    s = cyc;
    sda_i = 1'b0;
    wait_cyc(s + 5); req_sel = 1'b1;
    wait_cyc(s + 6);
    check("t5_busy", {31'd0, busy}, 32'd1);
    check("t5_sel", {31'd0, sel}, 32'd0);
    wait_cyc(s + 8); sda_i = 1'b1;
    expect_ev(EV_SW, 1'b1, s + 31);
    wait_cyc(s + 30); check("t5_sel_hold", {31'd0, sel}, 32'd0);
    wait_cyc(s + 49);
    check("t5_drained", sb.size(), 32'd0);

    // START then SCL stuck low: timeout after 65535 unchanged clocks, then holdoff.
    t = cyc;
    sda_i = 1'b0;
    wait_cyc(t + 8); scl_i = 1'b0;
    expect_ev(EV_TMO, 1'b1, t + 65549);
    wait_cyc(t + 65548); check("t4_busy_pre", {31'd0, busy}, 32'd1);
    wait_cyc(t + 65564); check("t4_busy_hold", {31'd0, busy}, 32'd1);
    wait_cyc(t + 65565); check("t4_busy_idle", {31'd0, busy}, 32'd0);
    check("t4_drained", sb.size(), 32'd0);
    scl_i = 1'b1;
    repeat (6) @(negedge clk);
    sda_i = 1'b1;
    repeat (8) @(negedge clk);
    check("t4_busy_after_release", {31'd0, busy}, 32'd0);

    // Asynchronous reset in the middle of a transaction.
    u = cyc;
    sda_i = 1'b0;
    wait_cyc(u + 8);
    check("t6_busy_pre", {31'd0, busy}, 32'd1);
    check("t6_sel_pre", {31'd0, sel}, 32'd1);
    #2;
    rst = 1'b1; req_sel = 1'b0;
    #1;
    check("t6_sel_async", {31'd0, sel}, 32'd0);
    check("t6_busy_async", {31'd0, busy}, 32'd0);
    check("t6_sw_async", {31'd0, switch_done}, 32'd0);
    sda_i = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("t6_sel_after", {31'd0, sel}, 32'd0);
    check("t6_busy_after", {31'd0, busy}, 32'd0);

    check("sb_empty", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
